// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the MEM-stage multiply/divide unit.
//   mdu_op_t    - operation encoding driven by the pipeline on op_i
//   mdu_state_t - control FSM states of mdu_hilo_writer
//   DATA_W      - datapath width
//   DIV_ITERS   - radix-2 divide iterations (one per quotient bit)
//   CNT_W       - width of the divide iteration counter
package mdu_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_t;

endpackage : mdu_pkg

// File: rtl/div_radix2_step.sv
// div_radix2_step: one combinational iteration of an unsigned restoring divide.
//   rem      in  DATA_W  partial remainder
//   quo      in  DATA_W  dividend bits still to consume (MSB first), quotient
//                        bits shifted in at the LSB end
//   divisor  in  DATA_W  divisor magnitude (nonzero)
//   rem_next out DATA_W  remainder after this iteration
//   quo_next out DATA_W  shift register after this iteration
module div_radix2_step
    import mdu_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // The shifted remainder is below 2*divisor, so a 33-bit subtract suffices:
    // its MSB is set exactly when the divisor does not fit.
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        trial    = shifted - {1'b0, divisor};
        rem_next = shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], 1'b0};
        if (!trial[DATA_W]) begin
            rem_next = trial[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

endmodule : div_radix2_step

// File: rtl/mdu_hilo_writer.sv
// mdu_hilo_writer: MEM-stage multiply/divide unit producing one HI/LO update.
//   clk_i     in   1  clock, rising edge
//   rst_i     in   1  asynchronous active-high reset
//   start_i   in   1  launch request, qualified by op_i
//   op_i      in   3  mdu_op_t operation
//   src_a_i   in  32  multiplicand / dividend
//   src_b_i   in  32  multiplier / divisor
//   flush_i   in   1  abort current operation, suppress any write
//   busy_o    out  1  operation in flight
//   done_o    out  1  one-cycle completion pulse
//   new_hi_o  out 32  HI write data
//   w_hi_o    out  1  HI write enable
//   new_lo_o  out 32  LO write data
//   w_lo_o    out  1  LO write enable
module mdu_hilo_writer #(
    parameter int unsigned DIV_ITERS = mdu_pkg::DIV_ITERS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [2:0]                op_i,
    input  logic [mdu_pkg::DATA_W-1:0] src_a_i,
    input  logic [mdu_pkg::DATA_W-1:0] src_b_i,
    input  logic                      flush_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [mdu_pkg::DATA_W-1:0] new_hi_o,
    output logic                      w_hi_o,
    output logic [mdu_pkg::DATA_W-1:0] new_lo_o,
    output logic                      w_lo_o
);

    import mdu_pkg::*;

    mdu_state_t        state_q;
    mdu_op_t           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              q_neg_q;
    logic              r_neg_q;

    logic                is_mul_c;
    logic                is_div_c;
    logic                div_signed_c;
    logic                launch_c;
    logic                cnt_last_c;
    logic [DATA_W-1:0]   a_mag_c;
    logic [DATA_W-1:0]   b_mag_c;
    logic                mul_signed_c;
    logic [2*DATA_W-1:0] mul_a_c;
    logic [2*DATA_W-1:0] mul_b_c;
    logic [2*DATA_W-1:0] product_c;
    logic [DATA_W-1:0]   rem_next_c;
    logic [DATA_W-1:0]   quo_next_c;

    // Launch decode and operand magnitudes for the divider.
    always_comb begin
        is_mul_c     = (op_i == MDU_MULT) || (op_i == MDU_MULTU);
        is_div_c     = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
        div_signed_c = (op_i == MDU_DIV);
        launch_c     = start_i && !flush_i && (is_mul_c || is_div_c) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
        a_mag_c      = (div_signed_c && src_a_i[DATA_W-1]) ? (~src_a_i + DATA_W'(1)) : src_a_i;
        b_mag_c      = (div_signed_c && src_b_i[DATA_W-1]) ? (~src_b_i + DATA_W'(1)) : src_b_i;
        cnt_last_c   = (cnt_q == CNT_W'(DIV_ITERS - 1));
    end

    // One 64-bit multiplier serves both forms; sign extension selects MULT vs MULTU.
    always_comb begin
        mul_signed_c = (op_q == MDU_MULT);
        mul_a_c      = {{DATA_W{mul_signed_c & a_q[DATA_W-1]}}, a_q};
        mul_b_c      = {{DATA_W{mul_signed_c & b_q[DATA_W-1]}}, b_q};
        product_c    = mul_a_c * mul_b_c;
    end

    div_radix2_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (b_q),
        .rem_next (rem_next_c),
        .quo_next (quo_next_c)
    );

    // Control FSM with operand, iteration and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_NONE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (launch_c) begin
            op_q <= mdu_op_t'(op_i);
            a_q  <= src_a_i;
            if (is_mul_c) begin
                b_q     <= src_b_i;
                state_q <= ST_MUL;
            end else if (src_b_i == '0) begin
                // Divide by zero resolves immediately with a fixed result.
                hi_q    <= src_a_i;
                lo_q    <= '1;
                state_q <= ST_DONE;
            end else begin
                b_q     <= b_mag_c;
                rem_q   <= '0;
                quo_q   <= a_mag_c;
                q_neg_q <= div_signed_c & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
                r_neg_q <= div_signed_c & src_a_i[DATA_W-1];
                cnt_q   <= '0;
                state_q <= ST_DIV;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_MUL: begin
                    hi_q    <= product_c[2*DATA_W-1:DATA_W];
                    lo_q    <= product_c[DATA_W-1:0];
                    state_q <= ST_DONE;
                end
                ST_DIV: begin
                    rem_q <= rem_next_c;
                    quo_q <= quo_next_c;
                    if (cnt_last_c) begin
                        cnt_q   <= '0;
                        state_q <= ST_SIGN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SIGN: begin
                    // Quotient takes the XOR of operand signs, remainder the dividend sign.
                    lo_q    <= q_neg_q ? (~quo_q + DATA_W'(1)) : quo_q;
                    hi_q    <= r_neg_q ? (~rem_q + DATA_W'(1)) : rem_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write strobe is masked by a same-cycle flush.
    always_comb begin
        busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_SIGN);
        done_o   = (state_q == ST_DONE) && !flush_i;
        w_hi_o   = done_o;
        w_lo_o   = done_o;
        new_hi_o = hi_q;
        new_lo_o = lo_q;
    end

endmodule : mdu_hilo_writer

// File: tb/tb_mdu_hilo_writer.sv
// tb_mdu_hilo_writer: vector table plus hand sequences, scoreboarded HI/LO writes.
module tb_mdu_hilo_writer;

    import mdu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] new_hi_o;
    logic        w_hi_o;
    logic [31:0] new_lo_o;
    logic        w_lo_o;

    mdu_hilo_writer dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .src_a_i  (src_a_i),
        .src_b_i  (src_b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .new_hi_o (new_hi_o),
        .w_hi_o   (w_hi_o),
        .new_lo_o (new_lo_o),
        .w_lo_o   (w_lo_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   nchk = 0;
    int   nerr = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any write seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        if (done_o === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("new_hi", 64'(new_hi_o), 64'(e.hi));
                chk("new_lo", 64'(new_lo_o), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("w_hi_w_lo", 64'({w_hi_o, w_lo_o}), 64'd3);
            end
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        op_i    = MDU_NONE;
    endtask

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
        if (op == MDU_MULT || op == MDU_MULTU) return 2;
        if (b == 32'd0) return 1;
        return 34;
    endfunction

    // Reference arithmetic for randomly generated operations.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        logic signed [63:0] ps;
        logic [63:0]        pu;
        sa = a;
        sb_v = b;
        hi = 32'd0;
        lo = 32'd0;
        if (op == MDU_MULT) begin
            ps = 64'(sa) * 64'(sb_v);
            hi = ps[63:32];
            lo = ps[31:0];
        end else if (op == MDU_MULTU) begin
            pu = {32'd0, a} * {32'd0, b};
            hi = pu[63:32];
            lo = pu[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == MDU_DIV) begin
            lo = sa / sb_v;
            hi = sa % sb_v;
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic run_vec(input vec_t v);
        tick();
        chk("busy_at_launch", 64'(busy_o), 64'd0);
        drive(v.op, v.a, v.b);
        sb.push_back('{hi: v.hi, lo: v.lo, cyc: cyc + v.lat});
        for (int k = 1; k <= v.lat; k++) begin
            tick();
            if (k == 1) release_start();
            chk("busy", 64'(busy_o), 64'(k < v.lat));
        end
        tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        vec_t        v;
        int          d0;
        logic [31:0] hi;
        logic [31:0] lo;

        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 2};
        vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[3]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
        vecs[4]  = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34};
        vecs[5]  = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
        vecs[6]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
        vecs[7]  = '{MDU_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{MDU_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2};
        vecs[9]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 34};
        vecs[10] = '{MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         34};

        // Reset state.
        tick();
        tick();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hi", 64'(new_hi_o), 64'd0);
        chk("rst_lo", 64'(new_lo_o), 64'd0);
        chk("rst_we", 64'({w_hi_o, w_lo_o}), 64'd0);
        rst_i = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Random operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            v.op = 3'($urandom_range(1, 4));
            v.a  = $urandom;
            v.b  = $urandom >> $urandom_range(0, 28);
            if (v.b == 32'd0) v.b = 32'd3;
            if (v.op == MDU_DIV && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF) v.a = 32'd1;
            model(v.op, v.a, v.b, hi, lo);
            v.hi  = hi;
            v.lo  = lo;
            v.lat = lat_of(v.op, v.b);
            run_vec(v);
        end

        // Flush mid-divide: back to idle one cycle later, no write ever.
        d0 = done_cnt;
        tick();
        drive(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) release_start();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        repeat (40) tick();
        chk("flush_no_write", 64'(done_cnt), 64'(d0));

        // Flush coincident with start: nothing launches.
        tick();
        drive(MDU_MULT, 32'd3, 32'd4);
        flush_i = 1'b1;
        tick();
        release_start();
        flush_i = 1'b0;
        chk("flush_start_busy", 64'(busy_o), 64'd0);
        repeat (5) tick();
        chk("flush_start_no_write", 64'(done_cnt), 64'(d0));

        // Flush in the DONE cycle masks the write strobe.
        tick();
        drive(MDU_MULT, 32'd3, 32'd4);
        tick();
        release_start();
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        tick();
        chk("flush_done_masked", 64'({done_o, w_hi_o, w_lo_o}), 64'd0);
        flush_i = 1'b0;
        repeat (3) tick();
        chk("flush_done_no_write", 64'(done_cnt), 64'(d0));

        // Back-to-back: MULT launched in the DIVU's DONE cycle.
        tick();
        drive(MDU_DIVU, 32'd100, 32'd7);
        sb.push_back('{hi: 32'd2, lo: 32'd14, cyc: cyc + 34});
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 1) release_start();
        end
        chk("b2b_first_done", 64'(done_cnt), 64'(d0 + 1));
        drive(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA, cyc: cyc + 2});
        tick();
        release_start();
        tick();
        tick();
        chk("b2b_drained", 64'(sb.size()), 64'd0);
        chk("b2b_second_done", 64'(done_cnt), 64'(d0 + 2));
        sb.delete();

        // Asynchronous reset mid-divide.
        tick();
        drive(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        release_start();
        repeat (9) tick();
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_hi", 64'(new_hi_o), 64'd0);
        chk("arst_lo", 64'(new_lo_o), 64'd0);
        chk("arst_we", 64'({w_hi_o, w_lo_o}), 64'd0);
        d0 = done_cnt;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (40) tick();
        chk("arst_no_write", 64'(done_cnt), 64'(d0));
        chk("arst_idle", 64'(busy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule : tb_mdu_hilo_writer
